// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter: shares one Wishbone-style port between the SERV ibus and dbus.
// Round-robin between the two masters, one transaction per grant, with an
// optional watchdog that ends hung transactions with a synthetic ack.
module serv_bus_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          i_rst,
    // instruction bus (read only)
    input  logic [AW-1:0] i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    // data bus
    input  logic [AW-1:0] i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    // shared port
    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic          o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    // Counter is kept one bit wide when the watchdog is disabled so it never
    // collapses to a zero-width vector.
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t        state_r;
    logic          last_d_r;
    logic [CW-1:0] cnt_r;

    logic          gnt_i_s;
    logic          gnt_d_s;
    logic          gnt_cyc_s;
    logic          timeout_hit_s;

    assign gnt_i_s = (state_r == GNT_I);
    assign gnt_d_s = (state_r == GNT_D);

    // Request line of whichever master currently owns the port.
    always_comb begin
        gnt_cyc_s = 1'b0;
        case (state_r)
            GNT_I:   gnt_cyc_s = i_ibus_cyc;
            GNT_D:   gnt_cyc_s = i_dbus_cyc;
            default: gnt_cyc_s = 1'b0;
        endcase
    end

    // Watchdog fires on the last allowed grant cycle unless the slave acks;
    // a master that already dropped cyc is aborting and gets no ack at all.
    always_comb begin
        if (TIMEOUT > 0) begin
            timeout_hit_s = gnt_cyc_s && (cnt_r == CNT_LAST) && !i_wb_ack;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Grant FSM, round-robin history and watchdog counter.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_r  <= IDLE;
            last_d_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (i_ibus_cyc && i_dbus_cyc) begin
                        state_r <= last_d_r ? GNT_I : GNT_D;
                    end else if (i_dbus_cyc) begin
                        state_r <= GNT_D;
                    end else if (i_ibus_cyc) begin
                        state_r <= GNT_I;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT_I: begin
                    if (!i_ibus_cyc || i_wb_ack || timeout_hit_s) begin
                        state_r  <= IDLE;
                        last_d_r <= 1'b0;
                        cnt_r    <= '0;
                    end else begin
                        cnt_r    <= cnt_r + CW'(1);
                    end
                end
                GNT_D: begin
                    if (!i_dbus_cyc || i_wb_ack || timeout_hit_s) begin
                        state_r  <= IDLE;
                        last_d_r <= 1'b1;
                        cnt_r    <= '0;
                    end else begin
                        cnt_r    <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Shared-port request mux; cyc comes straight from the state register so
    // it has no path from the masters' cyc inputs and drops at once on reset.
    always_comb begin
        o_wb_cyc = 1'b0;
        o_wb_adr = '0;
        o_wb_dat = 32'h0000_0000;
        o_wb_sel = 4'h0;
        o_wb_we  = 1'b0;
        case (state_r)
            GNT_I: begin
                o_wb_cyc = 1'b1;
                o_wb_adr = i_ibus_adr;
                o_wb_dat = 32'h0000_0000;
                o_wb_sel = 4'hf;
                o_wb_we  = 1'b0;
            end
            GNT_D: begin
                o_wb_cyc = 1'b1;
                o_wb_adr = i_dbus_adr;
                o_wb_dat = i_dbus_dat;
                o_wb_sel = i_dbus_sel;
                o_wb_we  = i_dbus_we;
            end
            default: begin
                o_wb_cyc = 1'b0;
            end
        endcase
    end

    // Ack and read-data return: the ack reaches only the granted master in the
    // same cycle; a watchdog ack carries zero data.
    always_comb begin
        o_ibus_ack = gnt_i_s && i_ibus_cyc && (i_wb_ack || timeout_hit_s);
        o_dbus_ack = gnt_d_s && i_dbus_cyc && (i_wb_ack || timeout_hit_s);
        o_timeout  = timeout_hit_s;
        if (timeout_hit_s) begin
            o_ibus_rdt = 32'h0000_0000;
            o_dbus_rdt = 32'h0000_0000;
        end else begin
            o_ibus_rdt = i_wb_rdt;
            o_dbus_rdt = i_wb_rdt;
        end
    end

endmodule
